// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: holds debug and system resets low until the PLL lock
// has been stable for LOCK_STABLE_CYCLES, then releases debug first and
// system RELEASE_GAP cycles later. Any lock loss re-asserts both resets.
// Optional macro HARDRESET_EN adds a debug-requested system-only reset
// (HRST state). Without it, i_hardreset is ignored.
//
// state     | meaning
// WAIT_LOCK | waiting for synchronized lock, all outputs low
// STABLE    | counting consecutive lock cycles, outputs low
// DBG_REL   | debug reset released, counting gap before system release
// RUN       | both resets released
// HRST      | system reset held by debug request (HARDRESET_EN only)
module clk_rst_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16,
  parameter int HARDRESET_CYCLES   = 32
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_pll_locked,
  input  logic i_hardreset,
  output logic o_dbg_nrst,
  output logic o_sys_nrst,
  output logic o_locked
);

  localparam int MAX_LG = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
  localparam int MAX_P  = (MAX_LG > HARDRESET_CYCLES) ? MAX_LG : HARDRESET_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    DBG_REL,
`ifdef HARDRESET_EN
    RUN,
    HRST
`else
    RUN
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q1;
  logic             sync_q2;
  logic             lock_s;

`ifdef HARDRESET_EN
  localparam logic [CNT_W-1:0] HR_LAST = CNT_W'(HARDRESET_CYCLES - 1);
`else
  logic unused_hardreset;
  assign unused_hardreset = i_hardreset;
`endif

  assign lock_s = sync_q2;

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_pll_locked;
      sync_q2 <= sync_q1;
    end
  end

  // Sequencing FSM with registered reset outputs; lock loss has top priority
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      o_dbg_nrst <= 1'b0;
      o_sys_nrst <= 1'b0;
      o_locked   <= 1'b0;
    end else if (state != WAIT_LOCK && state != STABLE && !lock_s) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      o_dbg_nrst <= 1'b0;
      o_sys_nrst <= 1'b0;
      o_locked   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          o_dbg_nrst <= 1'b0;
          o_sys_nrst <= 1'b0;
          o_locked   <= 1'b0;
          if (lock_s) begin
            // The entry cycle already counts as the first stable cycle
            state <= STABLE;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            state      <= DBG_REL;
            cnt        <= '0;
            o_dbg_nrst <= 1'b1;
            o_locked   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DBG_REL: begin
          if (cnt == GAP_LAST) begin
            state      <= RUN;
            cnt        <= '0;
            o_sys_nrst <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
`ifdef HARDRESET_EN
          if (i_hardreset) begin
            state      <= HRST;
            cnt        <= '0;
            o_sys_nrst <= 1'b0;
          end
`endif
        end
`ifdef HARDRESET_EN
        HRST: begin
          // Counter saturates at the minimum pulse length while the request persists
          if (cnt == HR_LAST) begin
            if (!i_hardreset) begin
              state      <= RUN;
              cnt        <= '0;
              o_sys_nrst <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        default: begin
          state      <= WAIT_LOCK;
          cnt        <= '0;
          o_dbg_nrst <= 1'b0;
          o_sys_nrst <= 1'b0;
          o_locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule
